load_store_unit: RTL and testbench

Initiator side of the core's single-port data memory interface. Accepts one load or store request at a time from the execute stage over a valid/ready handshake. Drives the memory's word address, write data and write enable, and samples its combinational read data. Sub-word stores are done as read-modify-write; loads are returned lane-extracted and sign/zero-extended.

---
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-port data memory initiator with sub-word RMW.
// Byte/half support is built only when LSU_SUBWORD_EN is defined.
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_w_en,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RMW, S_WRITE, S_RESP
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        req_err;
   logic [31:0] load_val;

`ifdef LSU_SUBWORD_EN
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] shifted;
   logic [31:0] lane_mask;
   logic [4:0]  shamt;
   logic [31:0] merged;
   logic        sx;

   // Decode request legality and extract/merge the addressed lane
   always_comb begin
      req_err   = (req_size == 2'b11) ||
                  (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00);
      shamt     = {addr_q[1:0], 3'b000};
      shifted   = mem_read_data >> shamt;
      lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
      merged    = (mem_read_data & ~(lane_mask << shamt)) |
                  ((wdata_q & lane_mask) << shamt);
      sx        = 1'b0;
      load_val  = mem_read_data;
      if (size_q == 2'b00) begin
         sx       = ~uns_q & shifted[7];
         load_val = {{24{sx}}, shifted[7:0]};
      end else if (size_q == 2'b01) begin
         sx       = ~uns_q & shifted[15];
         load_val = {{16{sx}}, shifted[15:0]};
      end
   end
`else
   logic unused_nosub;

   // Only aligned word accesses are legal in this build
   always_comb begin
      req_err  = (req_size != 2'b10) || (req_addr[1:0] != 2'b00);
      load_val = mem_read_data;
   end

   assign unused_nosub = ^{req_unsigned, addr_q[1:0]};
`endif

   // Request registers and state, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef LSU_SUBWORD_EN
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef LSU_SUBWORD_EN
         size_q  <= size_d;
         uns_q   <= uns_d;
`endif
      end
   end

   // Next-state and memory-port drive
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      rdata_d        = rdata_q;
      err_d          = err_q;
`ifdef LSU_SUBWORD_EN
      size_d         = size_q;
      uns_d          = uns_q;
`endif
      req_ready      = 1'b0;
      rsp_valid      = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      mem_w_en       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            req_ready = ~rst;
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = req_err;
`ifdef LSU_SUBWORD_EN
               size_d  = req_size;
               uns_d   = req_unsigned;
`endif
               if (req_err)
                  state_d = S_RESP;
               else if (!req_we)
                  state_d = S_LOAD;
`ifdef LSU_SUBWORD_EN
               else if (req_size != 2'b10)
                  state_d = S_RMW;
`endif
               else
                  state_d = S_WRITE;
            end
         end
         S_LOAD: begin
            mem_address = {addr_q[31:2], 2'b00};
            rdata_d     = load_val;
            state_d     = S_RESP;
         end
`ifdef LSU_SUBWORD_EN
         S_RMW: begin
            mem_address = {addr_q[31:2], 2'b00};
            wdata_d     = merged;
            state_d     = S_WRITE;
         end
`endif
         S_WRITE: begin
            mem_address    = {addr_q[31:2], 2'b00};
            mem_write_data = wdata_q;
            mem_w_en       = 1'b1;
            state_d        = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
// Expectations follow LSU_SUBWORD_EN when defined for the build.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_w_en;
   logic [31:0] mem_read_data;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] rd;
      logic        er;
      int          lat;
   } exp_t;

   exp_t sb[$];

   logic [31:0] mem [0:63];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;
   time         acc_t;
   logic [31:0] exp_w20;

`ifdef LSU_SUBWORD_EN
   localparam bit SUB = 1'b1;
`else
   localparam bit SUB = 1'b0;
`endif

   load_store_unit dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_w_en       (mem_w_en),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   // Behavioural memory with a bench-side preload port
   always @(posedge clk) begin
      if (mem_w_en)
         mem[mem_address[7:2]] <= mem_write_data;
      else if (pl_en)
         mem[pl_idx] <= pl_data;
   end

   assign mem_read_data = mem[mem_address[7:2]];

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1;
      pl_idx = a[7:2];
      pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic issue(
      input  logic        we,
      input  logic [31:0] a,
      input  logic [31:0] wd,
      input  logic [1:0]  sz,
      input  logic        un,
      output logic [31:0] rd,
      output logic        er,
      output int          lat,
      output int          wc,
      output logic [31:0] wa
   );
      int n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b1;
      req_we = we;
      req_addr = a;
      req_wdata = wd;
      req_size = sz;
      req_unsigned = un;
      @(posedge clk);
      acc_t = $time;
      #1;
      req_valid = 1'b0;
      req_we = 1'($urandom_range(0, 1));
      req_addr = $urandom;
      req_wdata = $urandom;
      req_size = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom_range(0, 1));
      lat = 0;
      wc = 0;
      wa = '0;
      rd = 'x;
      er = 1'bx;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (mem_w_en) begin
            wc++;
            wa = mem_address;
         end
         if (rsp_valid) begin
            lat = c;
            rd = rsp_rdata;
            er = rsp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      req_size = 2'b10;
      req_unsigned = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready got %b want 1", req_ready);
      end
      vectors++;
      if ({rsp_valid, rsp_err, mem_w_en} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags got %b want 000",
                  {rsp_valid, rsp_err, mem_w_en});
      end
      vectors++;
      if ({rsp_rdata, mem_address, mem_write_data} !== 96'h0) begin
         miscompares++;
         $display("FAIL reset_data got %h %h %h want 0",
                  rsp_rdata, mem_address, mem_write_data);
      end
   endtask

   task automatic test_word();
      exp_t e;
      logic [31:0] rd, wa;
      logic er;
      int lat, wc;
      preload(32'h10, 32'h0);
      sb.push_back('{rd: 32'h0, er: 1'b0, lat: 2});
      issue(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat, wc, wa);
      e = sb.pop_front();
      vectors++;
      if (rd !== e.rd || er !== e.er || lat != e.lat) begin
         miscompares++;
         $display("FAIL word_store_rsp got %h/%b/%0d want %h/%b/%0d",
                  rd, er, lat, e.rd, e.er, e.lat);
      end
      vectors++;
      if (wc != 1 || wa !== 32'h10) begin
         miscompares++;
         $display("FAIL word_store_wen got %0d@%h want 1@00000010", wc, wa);
      end
      vectors++;
      if (mem[4] !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL word_store_mem got %h want deadbeef", mem[4]);
      end
      sb.push_back('{rd: 32'hDEADBEEF, er: 1'b0, lat: 2});
      issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat, wc, wa);
      e = sb.pop_front();
      vectors++;
      if (rd !== e.rd || er !== e.er || lat != e.lat || wc != 0) begin
         miscompares++;
         $display("FAIL word_load got %h/%b/%0d/%0d want %h/%b/%0d/0",
                  rd, er, lat, wc, e.rd, e.er, e.lat);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
         miscompares++;
         $display("FAIL rsp_hold got %h/%b want deadbeef/0",
                  rsp_rdata, rsp_err);
      end
   endtask

   task automatic test_byte_rmw();
      exp_t e;
      logic [31:0] rd, wa;
      logic er;
      int lat, wc;
      preload(32'h20, 32'h11223344);
      exp_w20 = SUB ? 32'h11AA3344 : 32'h11223344;
      if (SUB)
         sb.push_back('{rd: 32'h0, er: 1'b0, lat: 3});
      else
         sb.push_back('{rd: 32'h0, er: 1'b1, lat: 1});
      issue(1'b1, 32'h22, 32'h55AA, 2'b00, 1'b0, rd, er, lat, wc, wa);
      e = sb.pop_front();
      vectors++;
      if (rd !== e.rd || er !== e.er || lat != e.lat) begin
         miscompares++;
         $display("FAIL byte_store_rsp got %h/%b/%0d want %h/%b/%0d",
                  rd, er, lat, e.rd, e.er, e.lat);
      end
      vectors++;
      if (wc != (SUB ? 1 : 0)) begin
         miscompares++;
         $display("FAIL byte_store_wen got %0d want %0d", wc, SUB ? 1 : 0);
      end
      vectors++;
      if (mem[8] !== exp_w20) begin
         miscompares++;
         $display("FAIL byte_store_mem got %h want %h", mem[8], exp_w20);
      end
   endtask

   task automatic test_load_ext();
      logic [31:0] adr [6];
      logic [1:0]  siz [6];
      logic        uns [6];
      logic [31:0] res [6];
      exp_t e;
      logic [31:0] rd, wa;
      logic er;
      int lat, wc;
      adr[0] = 32'h33; siz[0] = 2'b00; uns[0] = 1'b0; res[0] = 32'hFFFFFF80;
      adr[1] = 32'h33; siz[1] = 2'b00; uns[1] = 1'b1; res[1] = 32'h00000080;
      adr[2] = 32'h32; siz[2] = 2'b01; uns[2] = 1'b0; res[2] = 32'hFFFF80F0;
      adr[3] = 32'h31; siz[3] = 2'b00; uns[3] = 1'b0; res[3] = 32'h0000007F;
      adr[4] = 32'h30; siz[4] = 2'b01; uns[4] = 1'b0; res[4] = 32'h00007F00;
      adr[5] = 32'h32; siz[5] = 2'b01; uns[5] = 1'b1; res[5] = 32'h000080F0;
      preload(32'h30, 32'h80F07F00);
      for (int i = 0; i < 6; i++) begin
         if (SUB)
            sb.push_back('{rd: res[i], er: 1'b0, lat: 2});
         else
            sb.push_back('{rd: 32'h0, er: 1'b1, lat: 1});
         issue(1'b0, adr[i], 32'h0, siz[i], uns[i], rd, er, lat, wc, wa);
         e = sb.pop_front();
         vectors++;
         if (rd !== e.rd || er !== e.er || lat != e.lat) begin
            miscompares++;
            $display("FAIL load_ext[%0d] got %h/%b/%0d want %h/%b/%0d",
                     i, rd, er, lat, e.rd, e.er, e.lat);
         end
      end
   endtask

   task automatic test_misaligned();
      logic        we [3];
      logic [31:0] adr [3];
      logic [1:0]  siz [3];
      exp_t e;
      logic [31:0] rd, wa;
      logic er;
      int lat, wc;
      we[0] = 1'b1; adr[0] = 32'h21; siz[0] = 2'b10;
      we[1] = 1'b0; adr[1] = 32'h23; siz[1] = 2'b01;
      we[2] = 1'b1; adr[2] = 32'h20; siz[2] = 2'b11;
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{rd: 32'h0, er: 1'b1, lat: 1});
         issue(we[i], adr[i], 32'hCAFEF00D, siz[i], 1'b0,
               rd, er, lat, wc, wa);
         e = sb.pop_front();
         vectors++;
         if (rd !== e.rd || er !== e.er || lat != e.lat || wc != 0) begin
            miscompares++;
            $display("FAIL misalign[%0d] got %h/%b/%0d/%0d want %h/%b/%0d/0",
                     i, rd, er, lat, wc, e.rd, e.er, e.lat);
         end
      end
      vectors++;
      if (mem[8] !== exp_w20) begin
         miscompares++;
         $display("FAIL misalign_mem got %h want %h", mem[8], exp_w20);
      end
   endtask

   task automatic test_reset_write();
      logic seen;
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b1;
      req_addr = SUB ? 32'h20 : 32'h20;
      req_wdata = 32'h5555_5577;
      req_size = SUB ? 2'b00 : 2'b10;
      req_unsigned = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      if (SUB)
         @(negedge clk);
      seen = mem_w_en;
      vectors++;
      if (seen !== 1'b1) begin
         miscompares++;
         $display("FAIL rstw_pre_wen got %b want 1", seen);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({mem_w_en, rsp_valid, req_ready} !== 3'b000) begin
         miscompares++;
         $display("FAIL rstw_async got %b want 000",
                  {mem_w_en, rsp_valid, req_ready});
      end
      vectors++;
      if ({mem_address, mem_write_data, rsp_rdata} !== 96'h0) begin
         miscompares++;
         $display("FAIL rstw_data got %h %h %h want 0",
                  mem_address, mem_write_data, rsp_rdata);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rstw_ready got %b want 1", req_ready);
      end
      vectors++;
      if (mem[8] !== exp_w20) begin
         miscompares++;
         $display("FAIL rstw_mem got %h want %h", mem[8], exp_w20);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [31:0] rd, wa;
      logic er;
      int lat, wc;
      time t0;
      for (int i = 0; i < 3; i++)
         sb.push_back('{rd: 32'hDEADBEEF, er: 1'b0, lat: 2});
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat, wc, wa);
         e = sb.pop_front();
         vectors++;
         if (rd !== e.rd || er !== e.er || lat != e.lat) begin
            miscompares++;
            $display("FAIL b2b[%0d] got %h/%b/%0d want %h/%b/%0d",
                     i, rd, er, lat, e.rd, e.er, e.lat);
         end
         if (i > 0) begin
            vectors++;
            if (acc_t - t0 != 30) begin
               miscompares++;
               $display("FAIL b2b_spacing[%0d] got %0t want 30",
                        i, acc_t - t0);
            end
         end
         t0 = acc_t;
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte_rmw();
      test_load_ext();
      test_misaligned();
      test_reset_write();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
